// File: rtl/xadac_axi_arbiter_if.sv
// ---------------------------------------------------------------------------
// xadac_axi_arbiter_if
// AXI bundle shared by the requester ports and the downstream port of
// xadac_axi_arbiter.
//   master : drives AW/W/AR and B/R readies (the side that issues requests)
//   slave  : drives AW/W/AR readies and the B/R responses
// ---------------------------------------------------------------------------
interface xadac_axi_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/xadac_axi_arbiter.sv
// ---------------------------------------------------------------------------
// xadac_axi_arbiter
// Round-robin arbiter sharing one AXI master port among NumSlv requesters.
// Read and write paths are arbitrated independently, one transaction in
// flight per path. Responses are steered back by the registered grant index.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   slv  : NumSlv requester ports (slave modport)
//   mst  : shared downstream port (master modport)
// ---------------------------------------------------------------------------
module xadac_axi_arbiter #(
  parameter int unsigned NumSlv = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  xadac_axi_arbiter_if.slave         slv [NumSlv],
  xadac_axi_arbiter_if.master        mst
);
  localparam int unsigned IdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1;
  typedef logic [IdxW-1:0] idx_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              valid;
  } ax_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
    logic                valid;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
    logic            valid;
  } b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic              valid;
  } r_t;

  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R}      r_state_e;

  // First requester at or after prio, wrapping modulo NumSlv.
  function automatic idx_t rr_pick(input logic [NumSlv-1:0] req, input idx_t prio);
    idx_t        pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NumSlv; k++) begin
      idx = 32'(prio) + k;
      if (idx >= NumSlv) idx = idx - NumSlv;
      if (!found && req[idx_t'(idx)]) begin
        found = 1'b1;
        pick  = idx_t'(idx);
      end
    end
    return pick;
  endfunction

  function automatic idx_t rr_next(input idx_t g);
    return (32'(g) == NumSlv - 1) ? '0 : idx_t'(32'(g) + 1);
  endfunction

  // Flattened requester side
  ax_t               slv_aw [NumSlv];
  ax_t               slv_ar [NumSlv];
  w_t                slv_w  [NumSlv];
  b_t                slv_b  [NumSlv];
  r_t                slv_r  [NumSlv];
  logic [NumSlv-1:0] slv_aw_valid, slv_ar_valid;
  logic [NumSlv-1:0] slv_aw_ready, slv_w_ready, slv_ar_ready;
  logic [NumSlv-1:0] slv_b_ready, slv_r_ready;

  // Flattened downstream side
  ax_t  mst_aw, mst_ar;
  w_t   mst_w;
  b_t   mst_b;
  r_t   mst_r;
  logic mst_aw_ready, mst_w_ready, mst_ar_ready, mst_b_ready, mst_r_ready;

  for (genvar i = 0; i < NumSlv; i++) begin : g_slv
    assign slv_aw[i] = '{id: slv[i].aw_id, addr: slv[i].aw_addr, len: slv[i].aw_len,
                         size: slv[i].aw_size, burst: slv[i].aw_burst, valid: slv[i].aw_valid};
    assign slv_ar[i] = '{id: slv[i].ar_id, addr: slv[i].ar_addr, len: slv[i].ar_len,
                         size: slv[i].ar_size, burst: slv[i].ar_burst, valid: slv[i].ar_valid};
    assign slv_w[i]  = '{data: slv[i].w_data, strb: slv[i].w_strb, last: slv[i].w_last,
                         valid: slv[i].w_valid};
    assign slv_aw_valid[i] = slv[i].aw_valid;
    assign slv_ar_valid[i] = slv[i].ar_valid;
    assign slv_b_ready[i]  = slv[i].b_ready;
    assign slv_r_ready[i]  = slv[i].r_ready;

    assign slv[i].aw_ready = slv_aw_ready[i];
    assign slv[i].w_ready  = slv_w_ready[i];
    assign slv[i].ar_ready = slv_ar_ready[i];
    assign slv[i].b_id     = slv_b[i].id;
    assign slv[i].b_resp   = slv_b[i].resp;
    assign slv[i].b_valid  = slv_b[i].valid;
    assign slv[i].r_id     = slv_r[i].id;
    assign slv[i].r_data   = slv_r[i].data;
    assign slv[i].r_resp   = slv_r[i].resp;
    assign slv[i].r_last   = slv_r[i].last;
    assign slv[i].r_valid  = slv_r[i].valid;
  end

  assign mst.aw_id    = mst_aw.id;
  assign mst.aw_addr  = mst_aw.addr;
  assign mst.aw_len   = mst_aw.len;
  assign mst.aw_size  = mst_aw.size;
  assign mst.aw_burst = mst_aw.burst;
  assign mst.aw_valid = mst_aw.valid;
  assign mst.w_data   = mst_w.data;
  assign mst.w_strb   = mst_w.strb;
  assign mst.w_last   = mst_w.last;
  assign mst.w_valid  = mst_w.valid;
  assign mst.b_ready  = mst_b_ready;
  assign mst.ar_id    = mst_ar.id;
  assign mst.ar_addr  = mst_ar.addr;
  assign mst.ar_len   = mst_ar.len;
  assign mst.ar_size  = mst_ar.size;
  assign mst.ar_burst = mst_ar.burst;
  assign mst.ar_valid = mst_ar.valid;
  assign mst.r_ready  = mst_r_ready;

  assign mst_aw_ready = mst.aw_ready;
  assign mst_w_ready  = mst.w_ready;
  assign mst_ar_ready = mst.ar_ready;
  assign mst_b = '{id: mst.b_id, resp: mst.b_resp, valid: mst.b_valid};
  assign mst_r = '{id: mst.r_id, data: mst.r_data, resp: mst.r_resp, last: mst.r_last,
                   valid: mst.r_valid};

  // ---------------------------------------------------------------- write path
  w_state_e w_state_q, w_state_d;
  idx_t     w_grant_q, w_grant_d, w_prio_q, w_prio_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      w_grant_q <= '0;
      w_prio_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_grant_q <= w_grant_d;
      w_prio_q  <= w_prio_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_grant_d = w_grant_q;
    w_prio_d  = w_prio_q;
    unique case (w_state_q)
      W_IDLE: if (|slv_aw_valid) begin
        w_grant_d = rr_pick(slv_aw_valid, w_prio_q);
        w_state_d = W_AW;
      end
      W_AW: if (mst_aw.valid && mst_aw_ready) w_state_d = W_W;
      W_W:  if (mst_w.valid && mst_w_ready && mst_w.last) w_state_d = W_B;
      W_B:  if (mst_b.valid && mst_b_ready) begin
        w_prio_d  = rr_next(w_grant_q);
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Each phase opens exactly one channel toward the granted port; all other
  // outputs stay zero so idle ports see a quiet bus.
  always_comb begin
    mst_aw       = '0;
    mst_w        = '0;
    mst_b_ready  = 1'b0;
    slv_aw_ready = '0;
    slv_w_ready  = '0;
    for (int i = 0; i < NumSlv; i++) slv_b[i] = '0;
    unique case (w_state_q)
      W_AW: begin
        mst_aw                  = slv_aw[w_grant_q];
        slv_aw_ready[w_grant_q] = mst_aw_ready;
      end
      W_W: begin
        mst_w                  = slv_w[w_grant_q];
        slv_w_ready[w_grant_q] = mst_w_ready;
      end
      W_B: begin
        slv_b[w_grant_q] = mst_b;
        mst_b_ready      = slv_b_ready[w_grant_q];
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- read path
  r_state_e r_state_q, r_state_d;
  idx_t     r_grant_q, r_grant_d, r_prio_q, r_prio_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      r_grant_q <= '0;
      r_prio_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_grant_q <= r_grant_d;
      r_prio_q  <= r_prio_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_grant_d = r_grant_q;
    r_prio_d  = r_prio_q;
    unique case (r_state_q)
      R_IDLE: if (|slv_ar_valid) begin
        r_grant_d = rr_pick(slv_ar_valid, r_prio_q);
        r_state_d = R_AR;
      end
      R_AR: if (mst_ar.valid && mst_ar_ready) r_state_d = R_R;
      R_R:  if (mst_r.valid && mst_r_ready && mst_r.last) begin
        r_prio_d  = rr_next(r_grant_q);
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    mst_ar       = '0;
    mst_r_ready  = 1'b0;
    slv_ar_ready = '0;
    for (int i = 0; i < NumSlv; i++) slv_r[i] = '0;
    unique case (r_state_q)
      R_AR: begin
        mst_ar                  = slv_ar[r_grant_q];
        slv_ar_ready[r_grant_q] = mst_ar_ready;
      end
      R_R: begin
        slv_r[r_grant_q] = mst_r;
        mst_r_ready      = slv_r_ready[r_grant_q];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_xadac_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xadac_axi_arbiter
// Directed scenarios followed by randomized rounds for a 2-port arbiter.
// The bench plays both the requesters and the downstream memory; the grant
// order is predicted from the round-robin rule with a per-path priority
// pointer kept as a plain integer.
// ---------------------------------------------------------------------------
module tb_xadac_axi_arbiter;
  localparam int N = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  xadac_axi_arbiter_if slv_if [N] ();
  xadac_axi_arbiter_if mst_if ();

  xadac_axi_arbiter #(.NumSlv(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .slv  (slv_if),
    .mst  (mst_if)
  );

  // Requester-side stimulus and observation, one entry per port
  logic [N-1:0] s_aw_valid, s_w_valid, s_w_last, s_b_ready, s_ar_valid, s_r_ready;
  logic [31:0]  s_aw_addr [N];
  logic [31:0]  s_ar_addr [N];
  logic [3:0]   s_aw_id [N];
  logic [3:0]   s_ar_id [N];
  logic [7:0]   s_aw_len [N];
  logic [7:0]   s_ar_len [N];
  logic [63:0]  s_w_data [N];
  logic [63:0]  wbeats [N][16];

  logic [N-1:0] o_aw_ready, o_w_ready, o_b_valid, o_ar_ready, o_r_valid, o_r_last;
  logic [3:0]   o_b_id [N];
  logic [3:0]   o_r_id [N];
  logic [63:0]  o_r_data [N];

  for (genvar g = 0; g < N; g++) begin : g_port
    assign slv_if[g].aw_valid = s_aw_valid[g];
    assign slv_if[g].aw_addr  = s_aw_addr[g];
    assign slv_if[g].aw_id    = s_aw_id[g];
    assign slv_if[g].aw_len   = s_aw_len[g];
    assign slv_if[g].aw_size  = 3'd3;
    assign slv_if[g].aw_burst = 2'b01;
    assign slv_if[g].w_valid  = s_w_valid[g];
    assign slv_if[g].w_data   = s_w_data[g];
    assign slv_if[g].w_strb   = 8'hFF;
    assign slv_if[g].w_last   = s_w_last[g];
    assign slv_if[g].b_ready  = s_b_ready[g];
    assign slv_if[g].ar_valid = s_ar_valid[g];
    assign slv_if[g].ar_addr  = s_ar_addr[g];
    assign slv_if[g].ar_id    = s_ar_id[g];
    assign slv_if[g].ar_len   = s_ar_len[g];
    assign slv_if[g].ar_size  = 3'd3;
    assign slv_if[g].ar_burst = 2'b01;
    assign slv_if[g].r_ready  = s_r_ready[g];

    assign o_aw_ready[g] = slv_if[g].aw_ready;
    assign o_w_ready[g]  = slv_if[g].w_ready;
    assign o_b_valid[g]  = slv_if[g].b_valid;
    assign o_b_id[g]     = slv_if[g].b_id;
    assign o_ar_ready[g] = slv_if[g].ar_ready;
    assign o_r_valid[g]  = slv_if[g].r_valid;
    assign o_r_last[g]   = slv_if[g].r_last;
    assign o_r_id[g]     = slv_if[g].r_id;
    assign o_r_data[g]   = slv_if[g].r_data;
  end

  int checks = 0;
  int errors = 0;
  int w_prio_m = 0;
  int r_prio_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Round-robin rule: first requester at or after prio, modulo N.
  function automatic int rr(input int mask, input int prio);
    for (int k = 0; k < N; k++) begin
      int idx = (prio + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic setup_write(input int g, input int nbeats);
    s_aw_addr[g]  = 32'($urandom_range(0, 32'h0FFF_FFF8)) | (32'(g) << 28);
    s_aw_id[g]    = 4'(g * 4 + int'($urandom_range(0, 3)));
    s_aw_len[g]   = 8'(nbeats - 1);
    for (int k = 0; k < nbeats; k++) wbeats[g][k] = {$urandom, $urandom};
    s_aw_valid[g] = 1'b1;
    s_w_data[g]   = wbeats[g][0];
    s_w_last[g]   = (nbeats == 1);
    s_w_valid[g]  = 1'b1;
  endtask

  task automatic setup_read(input int g);
    s_ar_addr[g]  = 32'($urandom_range(0, 32'h0FFF_FFF8)) | (32'(g) << 28);
    s_ar_id[g]    = 4'(g * 4 + int'($urandom_range(0, 3)));
    s_ar_len[g]   = 8'($urandom_range(0, 3));
    s_ar_valid[g] = 1'b1;
  endtask

  task automatic do_write(input int g, input int nbeats);
    int o = 1 - g;
    int n;
    int k;
    bit hs;
    n = 0;
    while (mst_if.aw_valid !== 1'b1 && n < 8) begin
      chk("w_ready_before_aw_wait", o_w_ready[g], 1'b0);
      tick();
      n++;
    end
    chk("aw_valid_granted", mst_if.aw_valid, 1'b1);
    chk("aw_addr", mst_if.aw_addr, s_aw_addr[g]);
    chk("aw_id", mst_if.aw_id, s_aw_id[g]);
    chk("aw_len", mst_if.aw_len, s_aw_len[g]);
    chk("w_ready_before_aw", o_w_ready[g], 1'b0);
    chk("mst_w_valid_before_aw", mst_if.w_valid, 1'b0);
    hs = 0;
    n  = 0;
    while (!hs && n < 20) begin
      mst_if.aw_ready = ($urandom_range(0, 2) != 0) || (n > 8);
      #1;
      chk("aw_ready_route", o_aw_ready[g], mst_if.aw_ready);
      chk("aw_ready_other", o_aw_ready[o], 1'b0);
      hs = mst_if.aw_ready;
      tick();
      n++;
    end
    mst_if.aw_ready = 1'b0;
    s_aw_valid[g]   = 1'b0;
    s_b_ready[g]    = 1'b1;
    k = 0;
    n = 0;
    while (k < nbeats && n < 60) begin
      s_w_data[g]    = wbeats[g][k];
      s_w_last[g]    = (k == nbeats - 1);
      s_w_valid[g]   = 1'b1;
      mst_if.w_ready = ($urandom_range(0, 1) == 1) || (n > 40);
      #1;
      chk("w_valid_fwd", mst_if.w_valid, 1'b1);
      chk("w_data", mst_if.w_data, wbeats[g][k]);
      chk("w_last", mst_if.w_last, (k == nbeats - 1));
      chk("w_ready_route", o_w_ready[g], mst_if.w_ready);
      chk("w_ready_other", o_w_ready[o], 1'b0);
      chk("aw_blocked_in_w", mst_if.aw_valid, 1'b0);
      chk("b_ready_before_last", mst_if.b_ready, 1'b0);
      hs = mst_if.w_ready;
      tick();
      if (hs) k++;
      n++;
    end
    chk("w_beats_done", k, nbeats);
    s_w_valid[g]   = 1'b0;
    s_w_last[g]    = 1'b0;
    mst_if.w_ready = 1'b0;
    mst_if.b_valid = 1'b1;
    mst_if.b_id    = s_aw_id[g];
    mst_if.b_resp  = 2'b00;
    hs = 0;
    n  = 0;
    while (!hs && n < 20) begin
      s_b_ready[g] = ($urandom_range(0, 1) == 1) || (n > 8);
      #1;
      chk("b_valid_route", o_b_valid[g], 1'b1);
      chk("b_valid_other", o_b_valid[o], 1'b0);
      chk("b_id_route", o_b_id[g], s_aw_id[g]);
      chk("b_id_other", o_b_id[o], 4'h0);
      chk("b_ready_fwd", mst_if.b_ready, s_b_ready[g]);
      chk("w_valid_in_b", mst_if.w_valid, 1'b0);
      hs = s_b_ready[g];
      tick();
      n++;
    end
    mst_if.b_valid = 1'b0;
    s_b_ready[g]   = 1'b0;
    w_prio_m = (g + 1) % N;
    #1;
    chk("b_valid_after_done", o_b_valid[g], 1'b0);
    chk("aw_idle_gap", mst_if.aw_valid, 1'b0);
  endtask

  task automatic do_read(input int g);
    int o = 1 - g;
    int nbeats = int'(s_ar_len[g]) + 1;
    int n;
    int k;
    bit hs;
    logic [63:0] rb [16];
    for (int i = 0; i < nbeats; i++) rb[i] = {$urandom, $urandom};
    n = 0;
    while (mst_if.ar_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("ar_valid_granted", mst_if.ar_valid, 1'b1);
    chk("ar_addr", mst_if.ar_addr, s_ar_addr[g]);
    chk("ar_id", mst_if.ar_id, s_ar_id[g]);
    chk("ar_len", mst_if.ar_len, s_ar_len[g]);
    s_r_ready[g] = 1'b1;
    hs = 0;
    n  = 0;
    while (!hs && n < 20) begin
      mst_if.ar_ready = ($urandom_range(0, 2) != 0) || (n > 8);
      #1;
      chk("ar_ready_route", o_ar_ready[g], mst_if.ar_ready);
      chk("ar_ready_other", o_ar_ready[o], 1'b0);
      chk("r_ready_before_ar", mst_if.r_ready, 1'b0);
      hs = mst_if.ar_ready;
      tick();
      n++;
    end
    mst_if.ar_ready = 1'b0;
    s_ar_valid[g]   = 1'b0;
    k = 0;
    n = 0;
    while (k < nbeats && n < 60) begin
      mst_if.r_valid = 1'b1;
      mst_if.r_data  = rb[k];
      mst_if.r_last  = (k == nbeats - 1);
      mst_if.r_id    = s_ar_id[g];
      mst_if.r_resp  = 2'b00;
      s_r_ready[g]   = ($urandom_range(0, 1) == 1) || (n > 40);
      #1;
      chk("r_valid_route", o_r_valid[g], 1'b1);
      chk("r_valid_other", o_r_valid[o], 1'b0);
      chk("r_data_route", o_r_data[g], rb[k]);
      chk("r_data_other", o_r_data[o], 64'h0);
      chk("r_last_route", o_r_last[g], (k == nbeats - 1));
      chk("r_id_route", o_r_id[g], s_ar_id[g]);
      chk("r_ready_fwd", mst_if.r_ready, s_r_ready[g]);
      chk("ar_blocked_in_r", mst_if.ar_valid, 1'b0);
      hs = s_r_ready[g];
      tick();
      if (hs) k++;
      n++;
    end
    chk("r_beats_done", k, nbeats);
    mst_if.r_valid = 1'b0;
    mst_if.r_last  = 1'b0;
    s_r_ready[g]   = 1'b0;
    r_prio_m = (g + 1) % N;
    #1;
    chk("r_valid_after_done", o_r_valid[g], 1'b0);
    chk("ar_idle_gap", mst_if.ar_valid, 1'b0);
  endtask

  task automatic clear_all();
    s_aw_valid = '0; s_w_valid = '0; s_w_last = '0; s_b_ready = '0;
    s_ar_valid = '0; s_r_ready = '0;
    for (int i = 0; i < N; i++) begin
      s_aw_addr[i] = '0; s_ar_addr[i] = '0; s_aw_id[i] = '0; s_ar_id[i] = '0;
      s_aw_len[i]  = '0; s_ar_len[i]  = '0; s_w_data[i] = '0;
    end
    mst_if.aw_ready = 1'b0; mst_if.w_ready = 1'b0; mst_if.ar_ready = 1'b0;
    mst_if.b_valid  = 1'b0; mst_if.b_id    = '0;   mst_if.b_resp   = '0;
    mst_if.r_valid  = 1'b0; mst_if.r_id    = '0;   mst_if.r_data   = '0;
    mst_if.r_resp   = '0;   mst_if.r_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int wm;
    int rm;
    int g;
    int wlen [N];
    clear_all();

    // Reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mst_aw_valid", mst_if.aw_valid, 1'b0);
    chk("rst_mst_w_valid", mst_if.w_valid, 1'b0);
    chk("rst_mst_ar_valid", mst_if.ar_valid, 1'b0);
    chk("rst_mst_b_ready", mst_if.b_ready, 1'b0);
    chk("rst_mst_r_ready", mst_if.r_ready, 1'b0);
    chk("rst_slv_readies", {o_aw_ready, o_w_ready, o_ar_ready}, '0);
    chk("rst_slv_valids", {o_b_valid, o_r_valid}, '0);
    rstn = 1'b1;
    tick();

    // Single write from slv[1]: addr 0x100, data 0xDEADBEEF
    setup_write(1, 1);
    s_aw_addr[1] = 32'h100;
    wbeats[1][0] = 64'hDEADBEEF;
    s_w_data[1]  = 64'hDEADBEEF;
    #1;
    chk("lat_aw_before_edge", mst_if.aw_valid, 1'b0);
    tick();
    chk("lat_aw_after_edge", mst_if.aw_valid, 1'b1);
    chk("single_aw_addr", mst_if.aw_addr, 32'h100);
    chk("single_slv0_quiet", {o_aw_ready[0], o_w_ready[0], o_b_valid[0]}, 3'b000);
    do_write(rr(2'b10, w_prio_m), 1);

    // Read contention from both ports, twice
    for (int round = 0; round < 2; round++) begin
      setup_read(0);
      setup_read(1);
      rm = 3;
      while (rm != 0) begin
        g = rr(rm, r_prio_m);
        do_read(g);
        rm = rm & ~(1 << g);
      end
    end

    // Concurrent write (slv0) and read (slv1)
    setup_write(0, 1);
    setup_read(1);
    #1;
    chk("conc_aw_before", mst_if.aw_valid, 1'b0);
    chk("conc_ar_before", mst_if.ar_valid, 1'b0);
    tick();
    chk("conc_aw_valid", mst_if.aw_valid, 1'b1);
    chk("conc_ar_valid", mst_if.ar_valid, 1'b1);
    do_write(0, 1);
    do_read(1);

    // 4-beat burst from slv0 while slv1 waits with its AW
    setup_write(0, 4);
    tick();
    setup_write(1, 2);
    do_write(0, 4);
    do_write(rr(2'b10, w_prio_m), 2);

    // Early W: slv1 presents W three cycles before AW
    wbeats[1][0]  = 64'h0123_4567_89AB_CDEF;
    s_w_data[1]   = wbeats[1][0];
    s_w_last[1]   = 1'b1;
    s_w_valid[1]  = 1'b1;
    repeat (3) begin
      tick();
      chk("early_w_ready", o_w_ready[1], 1'b0);
      chk("early_mst_w_valid", mst_if.w_valid, 1'b0);
    end
    s_aw_addr[1]  = 32'h1000_0200;
    s_aw_id[1]    = 4'h6;
    s_aw_len[1]   = 8'd0;
    s_aw_valid[1] = 1'b1;
    do_write(1, 1);

    // Reset during the R phase
    setup_read(0);
    s_ar_len[0] = 8'd3;
    tick();
    mst_if.ar_ready = 1'b1;
    #1;
    chk("mid_ar_ready", o_ar_ready[0], 1'b1);
    tick();
    mst_if.ar_ready = 1'b0;
    s_ar_valid[0]   = 1'b0;
    mst_if.r_valid  = 1'b1;
    mst_if.r_data   = 64'hCAFE;
    mst_if.r_id     = s_ar_id[0];
    s_r_ready[0]    = 1'b1;
    #1;
    chk("mid_r_valid", o_r_valid[0], 1'b1);
    tick();
    rstn = 1'b0;
    #1;
    chk("rst_mid_r_valid", o_r_valid[0], 1'b0);
    chk("rst_mid_r_ready", mst_if.r_ready, 1'b0);
    chk("rst_mid_mst_valids", {mst_if.aw_valid, mst_if.w_valid, mst_if.ar_valid}, 3'b000);
    chk("rst_mid_slv_readies", {o_aw_ready, o_w_ready, o_ar_ready}, '0);
    clear_all();
    w_prio_m = 0;
    r_prio_m = 0;
    tick();
    rstn = 1'b1;
    tick();
    setup_read(1);
    #1;
    chk("post_rst_ar_before", mst_if.ar_valid, 1'b0);
    do_read(rr(2'b10, r_prio_m));

    // Randomized rounds on both paths
    for (int round = 0; round < 12; round++) begin
      wm = int'($urandom_range(0, 3));
      rm = int'($urandom_range(0, 3));
      for (int p = 0; p < N; p++) begin
        wlen[p] = int'($urandom_range(1, 4));
        if (wm[p]) setup_write(p, wlen[p]);
        if (rm[p]) setup_read(p);
      end
      tick();
      while (wm != 0) begin
        g = rr(wm, w_prio_m);
        do_write(g, wlen[g]);
        wm = wm & ~(1 << g);
      end
      while (rm != 0) begin
        g = rr(rm, r_prio_m);
        do_read(g);
        rm = rm & ~(1 << g);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
